// File: rtl/mux_scan.sv
// Scan sequencer for a registered 4:1 mux: walks sel through channels 0..3 NSCAN times,
// collects the registered mux output one cycle late and offers the packed word on valid/ready.
module mux_scan #(
    parameter int NSCAN = 2,
    parameter int DIV   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 mux_out,
    output logic [1:0]           sel,
    output logic                 busy,
    output logic [4*NSCAN-1:0]   data,
    output logic                 valid,
    input  logic                 ready,
    output logic [1:0]           dbg_state
);

    localparam int W  = 4 * NSCAN;
    localparam int SW = (W > 1) ? $clog2(W) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);
    localparam logic [DW-1:0] LAST_DIV  = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, OUT} state_t;

    state_t          state;
    logic [SW-1:0]   step;
    logic [DW-1:0]   divc;
    logic [W-2:0]    shreg;
    logic [SW-1:0]   step_inc;

    assign step_inc  = step + 1'b1;
    assign dbg_state = state;

    // Handshake: a word is transferred in any cycle where valid && ready at the rising edge;
    // data is stable while valid is high and valid never drops before the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
            divc  <= '0;
            shreg <= '0;
            sel   <= 2'd0;
            busy  <= 1'b0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sel <= 2'd0;
                    if (start) begin
                        state <= SCAN;
                        step  <= '0;
                        divc  <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    // mux_out now reflects the sel of the previous step's last cycle.
                    if (divc == '0 && step != '0)
                        shreg <= {mux_out, shreg[W-2:1]};
                    if (divc == LAST_DIV) begin
                        divc <= '0;
                        if (step == LAST_STEP) begin
                            state <= FLUSH;
                            step  <= '0;
                            sel   <= 2'd0;
                        end else begin
                            step <= step_inc;
                            sel  <= step_inc[1:0];
                        end
                    end else begin
                        divc <= divc + 1'b1;
                    end
                end
                FLUSH: begin
                    data  <= {mux_out, shreg};
                    valid <= 1'b1;
                    sel   <= 2'd0;
                    state <= OUT;
                end
                OUT: begin
                    sel <= 2'd0;
                    if (ready) begin
                        valid <= 1'b0;
                        if (cont) begin
                            state <= SCAN;
                            step  <= '0;
                            divc  <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: default instance (NSCAN=2, DIV=1) and a settle-time
// instance (NSCAN=1, DIV=3), each fed by a registered pattern[sel] mux model.
module tb_mux_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // default instance
    logic       a_start = 1'b0, a_cont = 1'b0, a_ready = 1'b0, a_mux_out;
    logic [1:0] a_sel, a_state;
    logic       a_busy, a_valid;
    logic [7:0] a_data;
    logic [3:0] a_pat = 4'b0000;

    // settle-time instance
    logic       b_start = 1'b0, b_cont = 1'b0, b_ready = 1'b0, b_mux_out;
    logic [1:0] b_sel, b_state;
    logic       b_busy, b_valid;
    logic [3:0] b_data;
    logic [3:0] b_pat = 4'b0000;

    int n_cmp = 0;
    int n_bad = 0;

    mux_scan u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .cont(a_cont), .mux_out(a_mux_out),
        .sel(a_sel), .busy(a_busy), .data(a_data), .valid(a_valid), .ready(a_ready),
        .dbg_state(a_state)
    );

    mux_scan #(.NSCAN(1), .DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .cont(b_cont), .mux_out(b_mux_out),
        .sel(b_sel), .busy(b_busy), .data(b_data), .valid(b_valid), .ready(b_ready),
        .dbg_state(b_state)
    );

    // registered upstream mux models
    always @(posedge clk) a_mux_out <= a_pat[a_sel];
    always @(posedge clk) b_mux_out <= b_pat[b_sel];

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (a_sel !== 2'd0)   begin n_bad++; $display("FAIL reset_a_sel got=%0d exp=0", a_sel); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
        n_cmp++; if (a_busy !== 1'b0)  begin n_bad++; $display("FAIL reset_a_busy got=%b exp=0", a_busy); end
        n_cmp++; if (a_data !== 8'h00) begin n_bad++; $display("FAIL reset_a_data got=%h exp=00", a_data); end
        n_cmp++; if (b_sel !== 2'd0)   begin n_bad++; $display("FAIL reset_b_sel got=%0d exp=0", b_sel); end
        n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
        n_cmp++; if (b_busy !== 1'b0)  begin n_bad++; $display("FAIL reset_b_busy got=%b exp=0", b_busy); end
        n_cmp++; if (b_data !== 4'h0)  begin n_bad++; $display("FAIL reset_b_data got=%h exp=0", b_data); end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (a_busy !== 1'b0 || a_sel !== 2'd0 || a_valid !== 1'b0) begin
                n_bad++; $display("FAIL idle_a cyc=%0d busy=%b sel=%0d valid=%b exp 0/0/0", c, a_busy, a_sel, a_valid);
            end
            n_cmp++; if (b_busy !== 1'b0 || b_sel !== 2'd0 || b_valid !== 1'b0) begin
                n_bad++; $display("FAIL idle_b cyc=%0d busy=%b sel=%0d valid=%b exp 0/0/0", c, b_busy, b_sel, b_valid);
            end
        end
    endtask

    task automatic test_single_word;
        a_pat = 4'b1101; a_ready = 1'b1; a_cont = 1'b0;
        @(posedge clk); #1; a_start = 1'b1;            // cycle 0
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1; a_start = 1'b0;
            if (c <= 8) begin
                n_cmp++; if (a_sel !== 2'(c - 1)) begin n_bad++; $display("FAIL single_sel cyc=%0d got=%0d exp=%0d", c, a_sel, 2'(c - 1)); end
            end
            n_cmp++; if (a_valid !== (c == 10)) begin n_bad++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", c, a_valid, (c == 10)); end
            n_cmp++; if (a_busy !== (c <= 10)) begin n_bad++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, a_busy, (c <= 10)); end
            if (c == 10) begin
                n_cmp++; if (a_data !== 8'b1101_1101) begin n_bad++; $display("FAIL single_data got=%b exp=11011101", a_data); end
            end
        end
    endtask

    task automatic test_settle;
        b_pat = 4'b0110; b_ready = 1'b1; b_cont = 1'b0;
        @(posedge clk); #1; b_start = 1'b1;            // cycle 0
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1; b_start = 1'b0;
            if (c <= 12) begin
                n_cmp++; if (b_sel !== 2'((c - 1) / 3)) begin n_bad++; $display("FAIL settle_sel cyc=%0d got=%0d exp=%0d", c, b_sel, 2'((c - 1) / 3)); end
            end
            n_cmp++; if (b_valid !== (c == 14)) begin n_bad++; $display("FAIL settle_valid cyc=%0d got=%b exp=%b", c, b_valid, (c == 14)); end
            n_cmp++; if (b_busy !== (c <= 14)) begin n_bad++; $display("FAIL settle_busy cyc=%0d got=%b exp=%b", c, b_busy, (c <= 14)); end
            if (c == 14) begin
                n_cmp++; if (b_data !== 4'b0110) begin n_bad++; $display("FAIL settle_data got=%b exp=0110", b_data); end
            end
        end
    endtask

    task automatic test_back_pressure;
        a_pat = 4'b1010; a_ready = 1'b0; a_cont = 1'b0;
        @(posedge clk); #1; a_start = 1'b1;            // cycle 0
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #1;
            a_start = (c >= 10 && c < 30);             // start pressed while stalled is ignored
            if (c >= 10 && c <= 30) begin
                n_cmp++; if (a_valid !== 1'b1 || a_data !== 8'b1010_1010) begin
                    n_bad++; $display("FAIL bp_hold cyc=%0d valid=%b data=%b exp 1/10101010", c, a_valid, a_data);
                end
                n_cmp++; if (a_sel !== 2'd0 || a_busy !== 1'b1) begin
                    n_bad++; $display("FAIL bp_idle_sel cyc=%0d sel=%0d busy=%b exp 0/1", c, a_sel, a_busy);
                end
            end
            if (c == 30) a_ready = 1'b1;                // handshake at end of cycle 30
            if (c >= 31) begin
                n_cmp++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
                    n_bad++; $display("FAIL bp_release cyc=%0d valid=%b busy=%b exp 0/0", c, a_valid, a_busy);
                end
            end
        end
    endtask

    task automatic test_continuous;
        logic [7:0] exp_w [3];
        exp_w[0] = 8'h33; exp_w[1] = 8'hCC; exp_w[2] = 8'h55;
        a_pat = 4'b0011; a_ready = 1'b1; a_cont = 1'b1;
        @(posedge clk); #1; a_start = 1'b1;            // cycle 0
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1; a_start = 1'b0;
            if (c == 9)  a_pat = 4'b1100;
            if (c == 19) a_pat = 4'b0101;
            if (c == 21) a_cont = 1'b0;
            n_cmp++; if (a_valid !== (c % 10 == 0)) begin n_bad++; $display("FAIL cont_valid cyc=%0d got=%b exp=%b", c, a_valid, (c % 10 == 0)); end
            n_cmp++; if (a_busy !== (c <= 30)) begin n_bad++; $display("FAIL cont_busy cyc=%0d got=%b exp=%b", c, a_busy, (c <= 30)); end
            if (c >= 11 && c <= 18) begin
                n_cmp++; if (a_sel !== 2'(c - 11)) begin n_bad++; $display("FAIL cont_sel cyc=%0d got=%0d exp=%0d", c, a_sel, 2'(c - 11)); end
            end
            if (c % 10 == 0) begin
                n_cmp++; if (a_data !== exp_w[c / 10 - 1]) begin n_bad++; $display("FAIL cont_data cyc=%0d got=%h exp=%h", c, a_data, exp_w[c / 10 - 1]); end
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        a_pat = 4'b0110; a_ready = 1'b1; a_cont = 1'b0;
        @(posedge clk); #1; a_start = 1'b1;            // cycle 0
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1; a_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_busy !== 1'b0)  begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
        n_cmp++; if (a_sel !== 2'd0)   begin n_bad++; $display("FAIL midrst_sel got=%0d exp=0", a_sel); end
        n_cmp++; if (a_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data got=%h exp=00", a_data); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
                n_bad++; $display("FAIL midrst_hold cyc=%0d valid=%b busy=%b exp 0/0", c, a_valid, a_busy);
            end
        end
        rst_n = 1'b1;
        a_pat = 4'b1101;
        @(posedge clk); #1; a_start = 1'b1;            // cycle 0
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1; a_start = 1'b0;
            n_cmp++; if (a_valid !== (c == 10)) begin n_bad++; $display("FAIL midrst_valid cyc=%0d got=%b exp=%b", c, a_valid, (c == 10)); end
            if (c == 10) begin
                n_cmp++; if (a_data !== 8'b1101_1101) begin n_bad++; $display("FAIL midrst_data2 got=%b exp=11011101", a_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_settle();
        test_back_pressure();
        test_continuous();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
# mux_scan

Scan sequencer and sample collector placed directly downstream of the registered 4:1 `mux` cell. It drives the mux `sel` lines through channels 0..3, `NSCAN` times per word. It captures the registered `out` bit for each channel after the mux's one-cycle register latency and packs the bits into a parallel word. The word is then presented on a valid/ready handshake.

## Interface
- `NSCAN`, default 2: full 4-channel scans per output word; must be ≥1. Word width W = 4*NSCAN.
- `DIV`, default 1: cycles each `sel` value is held (settle time); must be ≥1.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: request one word; sampled only in IDLE.
- `cont` input, 1 bit: continuous mode; sampled at the word handshake.
- `mux_out` input, 1 bit: registered output of the upstream mux.
- `sel` output, 2 bits: channel select driven to the mux.
- `busy` output, 1 bit: high in every state except IDLE.
- `data` output, W bits: packed samples. Bit 4*s+k = channel k of scan s.
- `valid` output, 1 bit: `data` is held stable while high.
- `ready` input, 1 bit: downstream accepts the word when `valid && ready`.

## Operation
- States: IDLE, SCAN, FLUSH, OUT. Reset forces IDLE; `sel`=0, `busy`=0, `valid`=0, `data`=0, all counters 0.
- IDLE: `sel`=0. If `start`=1, the next state is SCAN with step=0 and div=0.
- SCAN: step counter 0..4*NSCAN-1 (width clog2(4*NSCAN), min 1). `sel` = step[1:0]. Each step lasts DIV cycles, counted by a div counter of width clog2(DIV), min 1.
- Sampling rule: because the mux registers its output, `mux_out` in cycle t reflects `sel` from cycle t-1.
  - In the first cycle of step n (n≥1), the block stores `mux_out` into bit n-1 of an internal shift/index register.
  - After the last cycle of step 4*NSCAN-1, the state goes to FLUSH.
- FLUSH: one cycle with `sel`=0. Stores `mux_out` into bit 4*NSCAN-1. Loads the complete word into `data`. The next state is OUT.
- OUT: `valid`=1, `sel`=0, `data` held stable. On `valid && ready`:
  - If `cont`=1, go to SCAN with step=0.
  - Otherwise go to IDLE.
  - `valid` drops in the cycle after acceptance. `data` keeps its last value until the next FLUSH.
- `start` is ignored outside IDLE. `start` held high in IDLE after an accepted word starts a new word immediately.
- `ready` is ignored unless `valid`=1. The block never drops or overwrites a word that has not been accepted; back-pressure stalls in OUT indefinitely.
- Asserting `rst_n` low in any state, including mid-scan or during OUT, asynchronously forces reset values; any partial word is discarded.

## Timing
- `start` is sampled high in cycle 0 (IDLE).
  - SCAN occupies cycles 1..4*NSCAN*DIV.
  - FLUSH is cycle 4*NSCAN*DIV+1.
  - `valid`=1 from cycle 4*NSCAN*DIV+2.
  - With defaults: SCAN cycles 1–8, FLUSH cycle 9, `valid` at cycle 10.
- `sel` changes only on step boundaries. It is glitch-free, being registered and driven directly from the state/step registers.
- In continuous mode with `ready` tied high: words are spaced 4*NSCAN*DIV+2 cycles apart, and `valid` is high for exactly one cycle per word.
- `busy` goes high in the cycle after `start` is accepted. It goes low in the cycle after the final handshake when `cont`=0.

## Test plan
- Reset values: hold `rst_n`=0 → `sel`=0, `valid`=0, `busy`=0, `data`=0. Release `rst_n` → block stays in IDLE with `start`=0.
- Single word, defaults: the bench mux model registers pattern[sel], with ch0=1, ch1=0, ch2=1, ch3=1. Pulse `start` at cycle 0 with `ready`=1.
  - `sel` sequence over cycles 1–8: 0,1,2,3,0,1,2,3.
  - `valid` high at cycle 10 only, with `data`=8'b1101_1101.
  - `busy` low at cycle 11.
- Settle time, DIV=3, NSCAN=1: pattern ch0..ch3 = 0,1,1,0.
  - Each `sel` value is held 3 cycles.
  - `valid` at cycle 14 with `data`=4'b0110.
- Back-pressure: hold `ready`=0 for 20 cycles after `valid`.
  - `valid` and `data` stay stable.
  - `sel` stays 0 and no new scan starts.
  - Raising `ready` gives a handshake, then IDLE.
- Continuous mode: `cont`=1, `ready`=1, defaults, pattern changes between words → `valid` pulses every 10 cycles, each word matching the pattern active during its scan.
- Reset mid-scan: assert `rst_n`=0 at cycle 5 of a scan.
  - Outputs go to reset values immediately, with no `valid`.
  - A new `start` produces a correct full word at its cycle 10.
